// File: rtl/cpu_pkg.sv
// Shared CPU package: register-file widths, special register indices, types.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_wr_dec.sv
// One-hot write-row decoder for the register file.
// Row 0 never selects: $0 has no storage.
module reg_wr_dec
   import cpu_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [ADDR_W-1:0]      wa,
   input  logic                   we,
   output logic [2**ADDR_W-1:0]   wr_sel
);

   always_comb begin
      wr_sel = '0;
      for (int i = 1; i < 2**ADDR_W; i++) begin
         wr_sel[i] = we && (wa == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two read ports, one debug port, one write port.
// Optional write-through forwarding under macro REGFILE_WR_BYPASS_EN.
module reg_file
   import cpu_pkg::*;
#(
   parameter int                DATA_W  = REG_DATA_W,
   parameter int                ADDR_W  = REG_ADDR_W,
   parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0] wr_sel;
   logic [DATA_W-1:0]   mem [NUM_REGS];

   reg_wr_dec #(
      .ADDR_W (ADDR_W)
   ) u_dec (
      .wa     (wa),
      .we     (we),
      .wr_sel (wr_sel)
   );

   assign mem[0] = '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      localparam logic [DATA_W-1:0] RST_VAL =
         (i == int'(REG_SP)) ? SP_INIT : '0;

      logic [DATA_W-1:0] q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= RST_VAL;
         end else if (wr_sel[i]) begin
            q <= wd;
         end
      end

      assign mem[i] = q;
   end

   function automatic logic [DATA_W-1:0] rd_port(
      input logic [ADDR_W-1:0] a
   );
      logic [DATA_W-1:0] v;
      v = (a == '0) ? '0 : mem[a];
`ifdef REGFILE_WR_BYPASS_EN
      // Forward the in-flight write so a same-cycle reader sees it.
      if (rst_n && we && (wa != '0) && (a == wa)) begin
         v = wd;
      end
`endif
      return v;
   endfunction

   always_comb begin
      rd1      = rd_port(ra1);
      rd2      = rd_port(ra2);
      dbg_data = rd_port(dbg_addr);
   end

endmodule
